half_adder_checker: RTL and testbench
=====================================

// Module: half_adder_checker
// PURPOSE
//  Self-checking result monitor that sits directly downstream of the half-adder cell.
//  Samples the operands driven into the cell and the cell's sum/cout outputs.
//  Compares the outputs against a=^b / a&b after a configurable DUT latency.
//  Counts vectors, mismatches and input coverage, and reports a pass/fail verdict.
//  Synthesisable; usable on-chip as a BIST monitor or inside the half-adder bench.
// PARAMETERS
//  CNT_W  16  width of the vector and error counters (saturating)
//  LAT    0   DUT latency in clk cycles, from operands to sum/cout; legal range 0..4
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      1-cycle pulse: clear stats and begin a run (IDLE/DONE only)
//  stop         in   1      1-cycle pulse: end the run; drain in-flight vectors
//  sample_en    in   1      a/b valid this cycle (accepted only in RUN)
//  a            in   1      operand a as driven into the half adder
//  b            in   1      operand b as driven into the half adder
//  sum          in   1      half-adder sum output
//  cout         in   1      half-adder carry output
//  busy         out  1      1 in RUN or DRAIN
//  done         out  1      1 in DONE (level)
//  pass         out  1      valid in DONE: err_cnt==0 && cov==4'hF && vec_cnt!=0
//  err          out  1      sticky: first mismatch of the run seen
//  vec_cnt      out  CNT_W  vectors compared
//  err_cnt      out  CNT_W  mismatches
//  cov          out  4      bit {a,b} set once that input pair is compared
//  fail_ab      out  2      {a,b} of the first failing vector
//  fail_sc      out  2      {sum,cout} observed on the first failing vector
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; delay line cleared. Reset wins over all inputs.
//  FSM: IDLE -start-> RUN -stop-> DRAIN -(LAT cycles)-> DONE -start-> RUN.
//   With LAT=0, DRAIN lasts 0 cycles: RUN -stop-> DONE directly.
//   start is ignored in RUN/DRAIN; stop is ignored outside RUN.
//   A start+stop pulse in the same cycle in IDLE/DONE counts as start only.
//  start: in the same edge it clears vec_cnt, err_cnt, cov, err, fail_*, pass and the delay line.
//  Delay line: LAT-deep shift register of {valid,a,b}.
//   valid = sample_en in RUN, 0 otherwise. Shifts every cycle in RUN/DRAIN.
//   The stage compared at cycle t is the stage pushed at t-LAT. LAT=0 compares the current inputs.
//  Compare, when the delayed valid=1: exp = {a^b, a&b} of the delayed operands vs live {sum,cout}.
//   vec_cnt+1; cov[{a,b}]<=1.
//   On mismatch, err_cnt+1 and err<=1. If err was 0 before, also latch fail_ab/fail_sc.
//   Counters saturate at 2^CNT_W-1; they do not wrap. err stays 1 even when err_cnt saturates.
//  sample_en in the stop cycle is still accepted. sample_en in DRAIN/DONE/IDLE is ignored.
//  pass is registered on entry to DONE and is 0 in every other state.
//  Counter and cov values hold in DONE until the next start or rst.
//  rst mid-run aborts the run; no partial verdict is kept.
// TESTING
//  1 LAT=0: start; drive ab=00,01,10,11 with a correct DUT model; stop.
//    -> vec_cnt=4, err_cnt=0, cov=F, done=1, pass=1.
//  2 LAT=0: same 4 vectors, but cout is forced to 0 on ab=11.
//    -> err=1, err_cnt=1, fail_ab=2'b11, fail_sc=2'b00, pass=0.
//  3 LAT=2, pipelined model: 4 vectors, then stop in the last sample cycle.
//    -> busy for 2 more cycles, then done; vec_cnt=4, pass=1.
//  4 LAT=0: only ab=00,01 for 10 cycles; stop.
//    -> vec_cnt=10, cov=4'b0011, pass=0 (incomplete coverage).
//  5 CNT_W=3: 10 vectors, all mismatching.
//    -> vec_cnt=7, err_cnt=7 (saturated), fail_* hold the first vector.
//  6 rst asserted mid-RUN with vec_cnt=5; then a new start.
//    -> all outputs 0, state IDLE; start must be accepted; stats begin from 0.

Source files
------------

// File: rtl/half_adder_checker.sv
// Result monitor for a half-adder cell: compares sum/cout against a^b / a&b after
// a fixed DUT latency and accumulates vector, error and coverage statistics.
module half_adder_checker #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic             a,
  input  logic             b,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [1:0]       fail_ab,
  output logic [1:0]       fail_sc
);

  localparam int unsigned    DRAIN_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               clr;
  logic               active;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [2:0]         live;
  logic [2:0]         cmp;
  logic               cmp_en;
  logic               mism;
  logic [1:0]         exp_sc;

  logic [CNT_W-1:0]   vec_nxt, err_cnt_nxt;
  logic [3:0]         cov_nxt;
  logic               err_nxt, pass_nxt;
  logic [1:0]         fail_ab_nxt, fail_sc_nxt;

  assign active = (state == S_RUN) || (state == S_DRAIN);
  assign live   = {sample_en & (state == S_RUN), a, b};

  // Delay line of {valid,a,b}; with zero latency the live inputs are compared.
  if (LAT == 0) begin : g_nodl
    assign cmp = live;
  end else begin : g_dl
    logic [2:0] dl [LAT];
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        for (int i = 0; i < LAT; i++) dl[i] <= '0;
      end else if (active) begin
        dl[0] <= live;
        for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
      end
    end
    assign cmp = dl[LAT-1];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start takes priority over stop outside RUN
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          clr       = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) state_nxt = (LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_W'(LAT - 1)) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                   drain_cnt <= '0;
    else if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
    else                       drain_cnt <= '0;
  end

  assign cmp_en = cmp[2] & active;
  assign exp_sc = {cmp[1] ^ cmp[0], cmp[1] & cmp[0]};
  assign mism   = cmp_en && (exp_sc != {sum, cout});

  // Statistics update with saturating counters; verdict taken on entry to DONE
  always_comb begin
    vec_nxt     = vec_cnt;
    err_cnt_nxt = err_cnt;
    cov_nxt     = cov;
    err_nxt     = err;
    fail_ab_nxt = fail_ab;
    fail_sc_nxt = fail_sc;
    pass_nxt    = 1'b0;
    if (clr) begin
      vec_nxt     = '0;
      err_cnt_nxt = '0;
      cov_nxt     = '0;
      err_nxt     = 1'b0;
      fail_ab_nxt = '0;
      fail_sc_nxt = '0;
    end else if (cmp_en) begin
      if (vec_cnt != CNT_MAX) vec_nxt = vec_cnt + CNT_W'(1);
      cov_nxt[cmp[1:0]] = 1'b1;
      if (mism) begin
        if (err_cnt != CNT_MAX) err_cnt_nxt = err_cnt + CNT_W'(1);
        err_nxt = 1'b1;
        if (!err) begin
          fail_ab_nxt = cmp[1:0];
          fail_sc_nxt = {sum, cout};
        end
      end
    end
    if (state_nxt == S_DONE) begin
      if (state == S_DONE) pass_nxt = pass;
      else pass_nxt = (err_cnt_nxt == '0) && (cov_nxt == 4'hF) && (vec_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err     <= 1'b0;
      vec_cnt <= '0;
      err_cnt <= '0;
      cov     <= '0;
      fail_ab <= '0;
      fail_sc <= '0;
    end else begin
      busy    <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done    <= (state_nxt == S_DONE);
      pass    <= pass_nxt;
      err     <= err_nxt;
      vec_cnt <= vec_nxt;
      err_cnt <= err_cnt_nxt;
      cov     <= cov_nxt;
      fail_ab <= fail_ab_nxt;
      fail_sc <= fail_sc_nxt;
    end
  end

endmodule

// File: tb/tb_half_adder_checker.sv
// Directed bench for half_adder_checker: three instances (LAT=0, LAT=2, CNT_W=3)
// share operand stimulus; each sees its own sum/cout model.
module tb_half_adder_checker;

  logic clk = 1'b0;
  logic rst, start, stop, sample_en, a, b;
  logic fault_cout;

  logic sum0, cout0, sum2, cout2, sum3, cout3;
  logic [1:0] pipe1 = 2'b00;
  logic [1:0] pipe2 = 2'b00;

  logic        busy0, done0, pass0, err0;
  logic [15:0] vec0, errc0;
  logic [3:0]  cov0;
  logic [1:0]  fab0, fsc0;

  logic        busy2, done2, pass2, err2;
  logic [15:0] vec2, errc2;
  logic [3:0]  cov2;
  logic [1:0]  fab2, fsc2;

  logic        busy3, done3, pass3, err3;
  logic [2:0]  vec3, errc3;
  logic [3:0]  cov3;
  logic [1:0]  fab3, fsc3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Correct cell (optional cout fault), always-wrong cell, and 2-stage pipelined cell
  always_comb begin
    sum0  = a ^ b;
    cout0 = (a & b) & ~fault_cout;
    sum3  = ~(a ^ b);
    cout3 = a & b;
  end

  always @(posedge clk) begin
    pipe1 <= {a ^ b, a & b};
    pipe2 <= pipe1;
  end
  assign {sum2, cout2} = pipe2;

  half_adder_checker #(.CNT_W(16), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
    .a(a), .b(b), .sum(sum0), .cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .err(err0),
    .vec_cnt(vec0), .err_cnt(errc0), .cov(cov0), .fail_ab(fab0), .fail_sc(fsc0)
  );

  half_adder_checker #(.CNT_W(16), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
    .a(a), .b(b), .sum(sum2), .cout(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .err(err2),
    .vec_cnt(vec2), .err_cnt(errc2), .cov(cov2), .fail_ab(fab2), .fail_sc(fsc2)
  );

  half_adder_checker #(.CNT_W(3), .LAT(0)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
    .a(a), .b(b), .sum(sum3), .cout(cout3),
    .busy(busy3), .done(done3), .pass(pass3), .err(err3),
    .vec_cnt(vec3), .err_cnt(errc3), .cov(cov3), .fail_ab(fab3), .fail_sc(fsc3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs at a falling edge, then advance one full cycle
  task automatic drive(input logic va, input logic vb, input logic vs,
                       input logic st, input logic sp);
    a = va; b = vb; sample_en = vs; start = st; stop = sp;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic four_vectors();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_en = 1'b0;
    a = 1'b0; b = 1'b0; fault_cout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_stats", {pass0, err0, vec0, errc0, cov0, fab0, fsc0}, 0);

    // 1: all four pairs, correct cell
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_busy", busy0, 1);
    four_vectors();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_done", done0, 1);
    check("t1_busy_low", busy0, 0);
    check("t1_vec", vec0, 4);
    check("t1_errc", errc0, 0);
    check("t1_cov", cov0, 4'hF);
    check("t1_pass", pass0, 1);
    idle(4);

    // 2: cout stuck at 0 on ab=11
    fault_cout = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    four_vectors();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fault_cout = 1'b0;
    check("t2_err", err0, 1);
    check("t2_errc", errc0, 1);
    check("t2_fail_ab", fab0, 2'b11);
    check("t2_fail_sc", fsc0, 2'b00);
    check("t2_pass", pass0, 0);
    check("t2_vec", vec0, 4);
    idle(4);

    // 3: LAT=2, stop together with the last sample
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t3_drain1_busy", busy2, 1);
    check("t3_drain1_done", done2, 0);
    check("t3_lat0_done", done0, 1);
    check("t3_lat0_vec", vec0, 4);
    check("t3_lat0_pass", pass0, 1);
    idle(1);
    check("t3_drain2_busy", busy2, 1);
    idle(1);
    check("t3_done", done2, 1);
    check("t3_busy_low", busy2, 0);
    check("t3_vec", vec2, 4);
    check("t3_errc", errc2, 0);
    check("t3_pass", pass2, 1);
    idle(4);

    // 4: only 00/01 for ten cycles
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'(i % 2), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_vec", vec0, 10);
    check("t4_cov", cov0, 4'b0011);
    check("t4_pass", pass0, 0);
    check("t4_done", done0, 1);
    idle(4);

    // 5: 3-bit counters, every vector wrong, first vector ab=11
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 3; i < 13; i++) drive(1'((i >> 1) & 1), 1'(i & 1), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_vec_sat", vec3, 7);
    check("t5_errc_sat", errc3, 7);
    check("t5_err", err3, 1);
    check("t5_fail_ab", fab3, 2'b11);
    check("t5_fail_sc", fsc3, 2'b11);
    check("t5_pass", pass3, 0);
    check("t5_wide_vec", vec0, 10);
    idle(4);

    // 6: reset mid-run, ignored stop in IDLE, start+stop counts as start
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'(i >> 1 & 1), 1'(i & 1), 1'b1, 1'b0, 1'b0);
    check("t6_vec_pre", vec0, 5);
    check("t6_busy_pre", busy0, 1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check("t6_rst_busy", busy0, 0);
    check("t6_rst_done", done0, 0);
    check("t6_rst_stats", {pass0, err0, vec0, errc0, cov0, fab0, fsc0}, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_stop_idle", {busy0, done0}, 2'b00);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t6_start_stop", {busy0, done0}, 2'b10);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_vec", vec0, 1);
    check("t6_cov", cov0, 4'b0001);
    check("t6_done", done0, 1);
    check("t6_pass", pass0, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
